// File: rtl/branch_prediction_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters, fetch-stage
// lookup, ID-stage branch resolution with redirect on mispredict, and statistics counters.
module branch_prediction_unit #(
   parameter int CANT_BITS_ADDR        = 11,
   parameter int CANT_BITS_REGISTROS   = 32,
   parameter int CANT_BITS_FLAG_BRANCH = 3,
   parameter int CANT_ENTRADAS_BTB     = 16,
   parameter int CANT_BITS_CONTADOR    = 16
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic [CANT_BITS_ADDR-1:0]        i_pc_fetch,
   output logic                             o_pred_taken,
   output logic [CANT_BITS_ADDR-1:0]        o_pred_dir,
   input  logic                             i_enable_etapa,
   input  logic [CANT_BITS_FLAG_BRANCH-1:0] i_flag_branch,
   input  logic [CANT_BITS_ADDR-1:0]        i_pc_branch,
   input  logic [CANT_BITS_ADDR-1:0]        i_adder_pc,
   input  logic [CANT_BITS_REGISTROS-1:0]   i_immediate_address,
   input  logic [CANT_BITS_REGISTROS-1:0]   i_dato_reg_A,
   input  logic [CANT_BITS_REGISTROS-1:0]   i_dato_reg_B,
   input  logic                             i_pred_taken_id,
   input  logic [CANT_BITS_ADDR-1:0]        i_pred_dir_id,
   output logic                             o_branch_control,
   output logic [CANT_BITS_ADDR-1:0]        o_branch_dir,
   output logic [CANT_BITS_CONTADOR-1:0]    o_cant_branches,
   output logic [CANT_BITS_CONTADOR-1:0]    o_cant_mispredicts
);

   localparam int IDX  = $clog2(CANT_ENTRADAS_BTB);
   localparam int TAGW = CANT_BITS_ADDR - IDX;

   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_JR   = CANT_BITS_FLAG_BRANCH'(1);
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_JALR = CANT_BITS_FLAG_BRANCH'(2);
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_BEQ  = CANT_BITS_FLAG_BRANCH'(3);
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_BNE  = CANT_BITS_FLAG_BRANCH'(4);
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_J    = CANT_BITS_FLAG_BRANCH'(5);

   logic                      valid_reg  [CANT_ENTRADAS_BTB];
   logic [TAGW-1:0]           tag_reg    [CANT_ENTRADAS_BTB];
   logic [CANT_BITS_ADDR-1:0] target_reg [CANT_ENTRADAS_BTB];
   logic [1:0]                cnt_reg    [CANT_ENTRADAS_BTB];

   logic [CANT_BITS_CONTADOR-1:0] branches_reg;
   logic [CANT_BITS_CONTADOR-1:0] mispredicts_reg;

   logic [IDX-1:0]  fetch_idx;
   logic [TAGW-1:0] fetch_tag;
   logic            fetch_hit;

   assign fetch_idx    = i_pc_fetch[IDX-1:0];
   assign fetch_tag    = i_pc_fetch[CANT_BITS_ADDR-1:IDX];
   assign fetch_hit    = valid_reg[fetch_idx] && (tag_reg[fetch_idx] == fetch_tag);
   assign o_pred_taken = fetch_hit && cnt_reg[fetch_idx][1];
   assign o_pred_dir   = fetch_hit ? target_reg[fetch_idx] : '0;

   logic                      is_branch;
   logic                      actual_taken;
   logic [CANT_BITS_ADDR-1:0] actual_target;
   logic [CANT_BITS_ADDR-1:0] rel_target;
   logic                      mispredict;

   // PC-relative targets wrap modulo the address space.
   assign rel_target = i_adder_pc + i_immediate_address[CANT_BITS_ADDR-1:0];

   always_comb begin
      is_branch     = 1'b1;
      actual_taken  = 1'b0;
      actual_target = '0;
      case (i_flag_branch)
         FLAG_JR, FLAG_JALR: begin
            actual_taken  = 1'b1;
            actual_target = i_dato_reg_A[CANT_BITS_ADDR-1:0];
         end
         FLAG_BEQ: begin
            actual_taken  = (i_dato_reg_A == i_dato_reg_B);
            actual_target = rel_target;
         end
         FLAG_BNE: begin
            actual_taken  = (i_dato_reg_A != i_dato_reg_B);
            actual_target = rel_target;
         end
         FLAG_J: begin
            actual_taken  = 1'b1;
            actual_target = i_immediate_address[CANT_BITS_ADDR-1:0];
         end
         default: is_branch = 1'b0;
      endcase
   end

   assign mispredict = (actual_taken != i_pred_taken_id) ||
                       (actual_taken && (i_pred_dir_id != actual_target));

   always_comb begin
      o_branch_control = 1'b0;
      o_branch_dir     = '0;
      if (i_enable_etapa) begin
         o_branch_control = mispredict;
         o_branch_dir     = actual_taken ? actual_target : i_adder_pc;
      end
   end

   logic [IDX-1:0]  upd_idx;
   logic [TAGW-1:0] upd_tag;
   logic            upd_hit;

   assign upd_idx = i_pc_branch[IDX-1:0];
   assign upd_tag = i_pc_branch[CANT_BITS_ADDR-1:IDX];
   assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < CANT_ENTRADAS_BTB; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
            cnt_reg[i]    <= 2'd1;
         end
      end else if (i_enable_etapa) begin
         if (is_branch) begin
            if (upd_hit) begin
               if (actual_taken) begin
                  if (cnt_reg[upd_idx] != 2'd3) cnt_reg[upd_idx] <= cnt_reg[upd_idx] + 2'd1;
                  target_reg[upd_idx] <= actual_target;
               end else if (cnt_reg[upd_idx] != 2'd0) begin
                  cnt_reg[upd_idx] <= cnt_reg[upd_idx] - 2'd1;
               end
            end else if (actual_taken) begin
               valid_reg[upd_idx]  <= 1'b1;
               tag_reg[upd_idx]    <= upd_tag;
               target_reg[upd_idx] <= actual_target;
               cnt_reg[upd_idx]    <= 2'd2;
            end
         end else if (upd_hit) begin
            // A non-branch sitting in a BTB slot means the entry is stale.
            valid_reg[upd_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         branches_reg    <= '0;
         mispredicts_reg <= '0;
      end else begin
         if (i_enable_etapa && is_branch && !(&branches_reg))
            branches_reg <= branches_reg + 1'b1;
         if (o_branch_control && !(&mispredicts_reg))
            mispredicts_reg <= mispredicts_reg + 1'b1;
      end
   end

   assign o_cant_branches    = branches_reg;
   assign o_cant_mispredicts = mispredicts_reg;

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Self-checking bench for branch_prediction_unit: directed scenarios plus randomized
// traffic, compared against an arithmetic model of the BTB and resolution rules.
module tb_branch_prediction_unit;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic [10:0] i_pc_fetch = '0;
   logic        o_pred_taken;
   logic [10:0] o_pred_dir;
   logic        i_enable_etapa = 1'b0;
   logic [2:0]  i_flag_branch = '0;
   logic [10:0] i_pc_branch = '0;
   logic [10:0] i_adder_pc = '0;
   logic [31:0] i_immediate_address = '0;
   logic [31:0] i_dato_reg_A = '0;
   logic [31:0] i_dato_reg_B = '0;
   logic        i_pred_taken_id = 1'b0;
   logic [10:0] i_pred_dir_id = '0;
   logic        o_branch_control;
   logic [10:0] o_branch_dir;
   logic [15:0] o_cant_branches;
   logic [15:0] o_cant_mispredicts;

   branch_prediction_unit dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_pc_fetch(i_pc_fetch),
      .o_pred_taken(o_pred_taken), .o_pred_dir(o_pred_dir),
      .i_enable_etapa(i_enable_etapa), .i_flag_branch(i_flag_branch),
      .i_pc_branch(i_pc_branch), .i_adder_pc(i_adder_pc),
      .i_immediate_address(i_immediate_address),
      .i_dato_reg_A(i_dato_reg_A), .i_dato_reg_B(i_dato_reg_B),
      .i_pred_taken_id(i_pred_taken_id), .i_pred_dir_id(i_pred_dir_id),
      .o_branch_control(o_branch_control), .o_branch_dir(o_branch_dir),
      .o_cant_branches(o_cant_branches), .o_cant_mispredicts(o_cant_mispredicts)
   );

   always #5 i_clock = ~i_clock;

   int n_cmp = 0;
   int n_err = 0;
   int n_txn = 0;

   // Reference model: 16 slots, index = pc % 16, tag = pc / 16, counter as plain 0..3.
   bit m_valid [16];
   int m_tag   [16];
   int m_tgt   [16];
   int m_cnt   [16];
   int m_nbr   = 0;
   int m_nmis  = 0;

   int last_bc, last_bd;

   task automatic check(string tag, int obs, int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      m_nbr = 0; m_nmis = 0;
   endtask

   task automatic model_lookup(input int pc, output int hit, output int pt, output int pd);
      hit = (m_valid[pc % 16] && m_tag[pc % 16] == pc / 16) ? 1 : 0;
      pt  = (hit != 0 && m_cnt[pc % 16] >= 2) ? 1 : 0;
      pd  = (hit != 0) ? m_tgt[pc % 16] : 0;
   endtask

   task automatic model_resolve(input int flag, input int adder, input bit [31:0] imm,
                                input bit [31:0] a, input bit [31:0] b,
                                output int br, output int tk, output int tg);
      br = (flag >= 1 && flag <= 5) ? 1 : 0;
      tk = 0; tg = 0;
      case (flag)
         1, 2: begin tk = 1; tg = int'(a % 2048); end
         3:    begin tk = (a == b) ? 1 : 0; tg = (adder + int'(imm % 2048)) % 2048; end
         4:    begin tk = (a != b) ? 1 : 0; tg = (adder + int'(imm % 2048)) % 2048; end
         5:    begin tk = 1; tg = int'(imm % 2048); end
         default: ;
      endcase
   endtask

   // One transaction: drive at negedge, check combinational outputs, clock, check stats.
   task automatic txn(input bit en, input int flag, input int pcb, input bit [31:0] imm,
                      input bit [31:0] a, input bit [31:0] b, input bit pt_id,
                      input int pd_id, input int pcf);
      int adder, br, tk, tg, mis, hit, fpt, fpd, uhit, idx, exp_bc, exp_bd;
      @(negedge i_clock);
      adder = (pcb + 1) % 2048;
      i_enable_etapa = en; i_flag_branch = 3'(flag); i_pc_branch = 11'(pcb);
      i_adder_pc = 11'(adder); i_immediate_address = imm;
      i_dato_reg_A = a; i_dato_reg_B = b;
      i_pred_taken_id = pt_id; i_pred_dir_id = 11'(pd_id); i_pc_fetch = 11'(pcf);
      #1;
      model_lookup(pcf, hit, fpt, fpd);
      model_resolve(flag, adder, imm, a, b, br, tk, tg);
      mis = (tk != int'(pt_id) || (tk != 0 && pd_id != tg)) ? 1 : 0;
      exp_bc = (en && mis != 0) ? 1 : 0;
      exp_bd = en ? (tk != 0 ? tg : adder) : 0;
      last_bc = int'(o_branch_control);
      last_bd = int'(o_branch_dir);
      check("pred_taken", int'(o_pred_taken), fpt);
      check("pred_dir", int'(o_pred_dir), fpd);
      check("branch_control", last_bc, exp_bc);
      check("branch_dir", last_bd, exp_bd);
      @(posedge i_clock);
      if (en) begin
         idx  = pcb % 16;
         uhit = (m_valid[idx] && m_tag[idx] == pcb / 16) ? 1 : 0;
         if (br != 0) begin
            if (uhit != 0) begin
               m_cnt[idx] = tk != 0 ? ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3)
                                    : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
               if (tk != 0) m_tgt[idx] = tg;
            end else if (tk != 0) begin
               m_valid[idx] = 1; m_tag[idx] = pcb / 16; m_tgt[idx] = tg; m_cnt[idx] = 2;
            end
            if (m_nbr < 65535) m_nbr++;
         end else if (uhit != 0) begin
            m_valid[idx] = 0;
         end
         if (mis != 0 && m_nmis < 65535) m_nmis++;
      end
      #1;
      check("cant_branches", int'(o_cant_branches), m_nbr);
      check("cant_mispredicts", int'(o_cant_mispredicts), m_nmis);
      n_txn++;
      $display("txn %0d en=%0d flag=%0d pc=0x%0h fetch=0x%0h bc=%0d bd=0x%0h br=%0d mis=%0d",
               n_txn, en, flag, pcb, pcf, last_bc, last_bd, o_cant_branches, o_cant_mispredicts);
   endtask

   initial begin
      int hit, pt, pd, pcb, pcf, flag;
      bit [31:0] a, b, imm;
      bit pt_id;
      model_reset();
      i_reset = 1'b0;
      repeat (2) @(posedge i_clock);
      #1;
      check("reset_pred_taken", int'(o_pred_taken), 0);
      check("reset_cant_branches", int'(o_cant_branches), 0);
      @(negedge i_clock);
      i_reset = 1'b1;

      // Lookup after reset, then BEQ allocation and hit.
      txn(0, 0, 0, 0, 0, 0, 0, 0, 5);
      txn(1, 3, 5, 4, 7, 7, 0, 0, 5);
      check("beq_bc_const", last_bc, 1);
      check("beq_bd_const", last_bd, 10);
      txn(0, 0, 0, 0, 0, 0, 0, 0, 5);
      check("beq_hit_taken", int'(o_pred_taken), 1);
      check("beq_hit_dir", int'(o_pred_dir), 10);

      // Three not-taken resolutions walk the counter down.
      for (int k = 0; k < 3; k++) begin
         model_lookup(5, hit, pt, pd);
         txn(1, 3, 5, 4, 7, 8, pt[0], pd, 5);
      end

      // JR with correct and wrong predicted target.
      txn(1, 1, 40, 0, 32'h7FF, 0, 1, 11'h7FF, 40);
      check("jr_ok_bc", last_bc, 0);
      txn(1, 1, 40, 0, 32'h7FF, 0, 1, 11'h100, 40);
      check("jr_bad_bc", last_bc, 1);
      check("jr_bad_bd", last_bd, 11'h7FF);

      // Non-branch hitting the BTB invalidates the entry.
      txn(1, 0, 40, 0, 0, 0, 1, 0, 40);
      check("nb_bc", last_bc, 1);
      check("nb_bd", last_bd, 41);
      txn(0, 0, 0, 0, 0, 0, 0, 0, 40);
      check("nb_invalid", int'(o_pred_dir), 0);

      // BNE wrap and conflicting allocation.
      txn(1, 4, 11'h7FD, 5, 1, 2, 0, 0, 0);
      check("bne_wrap", last_bd, 3);
      txn(1, 5, 3, 100, 0, 0, 0, 0, 3);
      txn(1, 5, 19, 200, 0, 0, 0, 0, 3);
      txn(0, 0, 0, 0, 0, 0, 0, 0, 3);
      check("conflict_miss", int'(o_pred_dir), 0);

      // Randomized traffic over a small pc pool to force hits and conflicts.
      for (int n = 0; n < 250; n++) begin
         pcb  = $urandom_range(0, 7) + 16 * $urandom_range(0, 2);
         if ($urandom_range(0, 9) == 0) pcb = $urandom_range(0, 2047);
         pcf  = $urandom_range(0, 7) + 16 * $urandom_range(0, 2);
         flag = $urandom_range(0, 7);
         a    = $urandom;
         b    = $urandom_range(0, 1) ? a : $urandom;
         imm  = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            model_lookup(pcb, hit, pt, pd);
            pt_id = pt[0];
         end else begin
            pt_id = 1'($urandom_range(0, 1));
            pd    = $urandom_range(0, 2047);
         end
         txn(1'($urandom_range(0, 7) != 0), flag, pcb, imm, a, b, pt_id, pd, pcf);
      end

      // Reset pulsed during an enabled taken update.
      @(negedge i_clock);
      i_enable_etapa = 1'b1; i_flag_branch = 3'd5; i_pc_branch = 11'd9;
      i_immediate_address = 32'd77; i_pc_fetch = 11'd9;
      i_pred_taken_id = 1'b0;
      #2 i_reset = 1'b0;
      #1;
      check("rst_async_pred_dir", int'(o_pred_dir), 0);
      check("rst_async_branches", int'(o_cant_branches), 0);
      @(posedge i_clock);
      #1 i_reset = 1'b1;
      model_reset();
      txn(0, 0, 0, 0, 0, 0, 0, 0, 9);
      check("rst_table_empty", int'(o_pred_taken), 0);
      txn(1, 5, 9, 77, 0, 0, 0, 0, 9);
      txn(0, 0, 0, 0, 0, 0, 0, 0, 9);
      check("post_rst_alloc", int'(o_pred_dir), 77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_prediction_unit.md
BRANCH_PREDICTION_UNIT -- requirements
Module: branch_prediction_unit

Interface
REQ-001 SHALL have parameter CANT_BITS_ADDR, default 11, instruction address width.
REQ-002 SHALL have parameter CANT_BITS_REGISTROS, default 32, register data and immediate width.
REQ-003 SHALL have parameter CANT_BITS_FLAG_BRANCH, default 3, branch-type code width.
REQ-004 SHALL have parameter CANT_ENTRADAS_BTB, default 16, BTB depth, power of 2, at least 2; IDX = log2(depth).
REQ-005 SHALL have parameter CANT_BITS_CONTADOR, default 16, statistics counter width.
REQ-006 SHALL have port i_clock, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_pc_fetch, input, CANT_BITS_ADDR, PC of the instruction in fetch.
REQ-009 SHALL have ports o_pred_taken (output, 1) and o_pred_dir (output, CANT_BITS_ADDR): fetch-stage prediction.
REQ-010 SHALL have port i_enable_etapa, input, 1, ID-stage instruction valid.
REQ-011 SHALL have port i_flag_branch, input, CANT_BITS_FLAG_BRANCH: 0 none, 1 JR, 2 JALR, 3 BEQ, 4 BNE, 5 J/JAL, 6-7 none.
REQ-012 SHALL have inputs i_pc_branch and i_adder_pc (CANT_BITS_ADDR each): PC and PC+1 of the ID-stage instruction.
REQ-013 SHALL have inputs i_immediate_address, i_dato_reg_A and i_dato_reg_B (CANT_BITS_REGISTROS each).
REQ-014 SHALL have inputs i_pred_taken_id (1) and i_pred_dir_id (CANT_BITS_ADDR): the prediction carried down with the ID-stage instruction.
REQ-015 SHALL have outputs o_branch_control (1) and o_branch_dir (CANT_BITS_ADDR): flush/redirect request and its target.
REQ-016 SHALL have outputs o_cant_branches and o_cant_mispredicts (CANT_BITS_CONTADOR each): statistics.

Function
REQ-017 BTB SHALL be direct-mapped; each entry holds valid, tag, target and a 2-bit saturating counter; index = pc[IDX-1:0], tag = pc[CANT_BITS_ADDR-1:IDX].
REQ-018 Lookup SHALL be combinational: hit = valid and tag match on i_pc_fetch; o_pred_taken = hit and counter[1]; o_pred_dir = the entry target on hit, else 0.
REQ-019 Resolution SHALL be combinational, with actual taken/target per flag:
- 1, 2: taken, target = i_dato_reg_A[ADDR-1:0].
- 3: taken iff A == B; 4: taken iff A != B; target for both = i_adder_pc + i_immediate_address[ADDR-1:0], modulo 2^ADDR, wrap allowed.
- 5: taken, target = i_immediate_address[ADDR-1:0].
- 0, 6, 7: not taken.
REQ-020 Mispredict SHALL be asserted when actual taken differs from i_pred_taken_id, or when both are taken and i_pred_dir_id differs from the actual target; this applies to non-branch flags as well.
REQ-021 o_branch_control SHALL equal mispredict and i_enable_etapa; o_branch_dir = actual target if taken, else i_adder_pc; both outputs SHALL be 0 when i_enable_etapa = 0 (no latches).
REQ-022 On a clock edge with i_enable_etapa=1 and flag 1-5, if i_pc_branch hits: counter increments if taken, decrements if not, saturating at 3 and 0; target is updated only if taken.
REQ-023 On the same condition with a miss: allocate only if taken (valid=1, tag, target, counter=2); a not-taken miss leaves the table unchanged, overwriting the conflicting entry otherwise.
REQ-024 With i_enable_etapa=1, a non-branch flag and a hit on i_pc_branch, the entry SHALL be invalidated.
REQ-025 Lookup and update on the same index in the same cycle SHALL see pre-edge contents (no bypass); the update is visible from the next cycle.
REQ-026 o_cant_branches SHALL increment per enabled flag 1-5 and o_cant_mispredicts per cycle with o_branch_control=1; both saturate at all-ones.

Reset
REQ-027 While i_reset=0, all valid bits, tags, targets and statistics counters SHALL be cleared asynchronously and BTB counters set to 1; o_pred_taken=0 and o_pred_dir=0 follow.
REQ-028 Reset asserted mid-operation SHALL discard any pending update in that cycle; the first post-reset edge with enable performs a normal update.

Verification
REQ-029 Scenario: after reset, lookup pc=5 -> o_pred_taken=0, o_pred_dir=0; BEQ at pc=5, adder_pc=6, imm=4, A=B=7, pred 0 -> o_branch_control=1, o_branch_dir=10; next cycle lookup pc=5 -> taken, dir=10.
REQ-030 Scenario: same BEQ then 3 not-taken resolutions (A!=B) -> counter walks 2,1,0,0; prediction not-taken after the first; mispredicts only when the prediction differed.
REQ-031 Scenario: JR with A=0x7FF, pred taken dir=0x7FF -> o_branch_control=0; pred dir=0x100 -> o_branch_control=1, o_branch_dir=0x7FF.
REQ-032 Scenario: flag 0 with i_pred_taken_id=1 at pc hitting the BTB -> o_branch_control=1, o_branch_dir=i_adder_pc, entry invalid next cycle.
REQ-033 Scenario: BNE with adder_pc=0x7FE, imm=0x005, taken -> o_branch_dir=0x003 (wrap); 16-entry BTB, pc=3 then pc=19 taken -> pc=3 misses afterwards.
REQ-034 Scenario: reset pulsed during an enabled taken update -> table empty and counters 0 afterwards.
